conv_tile_loader: RTL and testbench

- Upstream stage of the convolution control path: it loads one tile of input feature map and weights from a single valid/ready stream into the banked on-chip buffers.
- Once the buffers are full, it raises `conv_computing_start` and holds it until `conv_computing_done` returns.
- It then reports `tile_done` and waits for the next `conv_load_start`.

---
 rtl/conv_tile_loader_if.sv | 41 ++++
 rtl/conv_tile_loader.sv | 172 +++++++++++++++++
 tb/tb_conv_tile_loader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_tile_loader_if.sv
// Stream, buffer-write and compute-handshake bundle for conv_tile_loader.
// Ports: stream (s_data/s_valid/s_ready), in_fm and weight bank write ports,
// load/compute control (conv_load_start, conv_computing_start/done),
// status (busy, tile_done). slave = loader side, master = environment side.
interface conv_tile_loader_if #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int Tn = 16,
    parameter int Tm = 16
);
    logic          conv_load_start;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [Tm-1:0] in_fm_wr_ena;
    logic [AW-1:0] in_fm_wr_addr;
    logic [DW-1:0] in_fm_wr_data;
    logic [Tn-1:0] weight_wr_ena;
    logic [AW-1:0] weight_wr_addr;
    logic [DW-1:0] weight_wr_data;
    logic          conv_computing_start;
    logic          conv_computing_done;
    logic          busy;
    logic          tile_done;

    modport slave (
        input  conv_load_start, s_data, s_valid, conv_computing_done,
        output s_ready,
        output in_fm_wr_ena, in_fm_wr_addr, in_fm_wr_data,
        output weight_wr_ena, weight_wr_addr, weight_wr_data,
        output conv_computing_start, busy, tile_done
    );

    modport master (
        output conv_load_start, s_data, s_valid, conv_computing_done,
        input  s_ready,
        input  in_fm_wr_ena, in_fm_wr_addr, in_fm_wr_data,
        input  weight_wr_ena, weight_wr_addr, weight_wr_data,
        input  conv_computing_start, busy, tile_done
    );
endinterface

// File: rtl/conv_tile_loader.sv
// Loads one tile of input feature map then weights from a single stream
// into banked buffers, then requests compute and reports tile completion.
// Ports: clk, rst (async, active-high), bus (conv_tile_loader_if.slave).
module conv_tile_loader #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int Tn = 16,
    parameter int Tm = 16,
    parameter int Tr = 64,
    parameter int Tc = 16,
    parameter int K  = 3
) (
    input  logic              clk,
    input  logic              rst,
    conv_tile_loader_if.slave bus
);
    localparam int BMAX     = (Tm > Tn) ? Tm : Tn;
    localparam int BW       = (BMAX > 1) ? $clog2(BMAX) : 1;
    localparam int IN_WORDS = Tr * Tc;
    localparam int WT_WORDS = Tm * K * K;

    localparam logic [AW-1:0] IN_LAST    = AW'(IN_WORDS - 1);
    localparam logic [AW-1:0] WT_LAST    = AW'(WT_WORDS - 1);
    localparam logic [BW-1:0] IN_BANK_LS = BW'(Tm - 1);
    localparam logic [BW-1:0] WT_BANK_LS = BW'(Tn - 1);

    generate
        if ((longint'(IN_WORDS) - 1) >= (longint'(1) << AW) ||
            (longint'(WT_WORDS) - 1) >= (longint'(1) << AW)) begin : g_aw_check
            $error("conv_tile_loader: AW too narrow for tile addresses");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        LOAD_IN,
        LOAD_WT,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          load_q;
    logic [BW-1:0] bank;
    logic [BW-1:0] bank_nx;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_nx;
    logic          accept;
    logic          start_rise;

    logic [Tm-1:0] in_ena_r;
    logic [AW-1:0] in_addr_r;
    logic [DW-1:0] in_data_r;
    logic [Tn-1:0] wt_ena_r;
    logic [AW-1:0] wt_addr_r;
    logic [DW-1:0] wt_data_r;
    logic          comp_start_r;
    logic          tile_done_r;

    assign bus.s_ready = (state == LOAD_IN) || (state == LOAD_WT);
    assign bus.busy    = (state != IDLE);
    assign accept      = bus.s_valid && bus.s_ready;
    assign start_rise  = bus.conv_load_start && !load_q;

    always_comb begin
        state_nx = state;
        bank_nx  = bank;
        addr_nx  = addr;
        unique case (state)
            IDLE: begin
                if (start_rise) state_nx = LOAD_IN;
            end
            LOAD_IN: begin
                if (accept) begin
                    if (addr == IN_LAST) begin
                        addr_nx = '0;
                        if (bank == IN_BANK_LS) begin
                            bank_nx  = '0;
                            state_nx = LOAD_WT;
                        end else begin
                            bank_nx = bank + BW'(1);
                        end
                    end else begin
                        addr_nx = addr + AW'(1);
                    end
                end
            end
            LOAD_WT: begin
                if (accept) begin
                    if (addr == WT_LAST) begin
                        addr_nx = '0;
                        if (bank == WT_BANK_LS) begin
                            bank_nx  = '0;
                            state_nx = ISSUE;
                        end else begin
                            bank_nx = bank + BW'(1);
                        end
                    end else begin
                        addr_nx = addr + AW'(1);
                    end
                end
            end
            // Lets the final weight write retire before compute is requested.
            ISSUE: state_nx = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.conv_computing_done) begin
                    state_nx = IDLE;
                    bank_nx  = '0;
                    addr_nx  = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                bank_nx  = '0;
                addr_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            load_q <= 1'b0;
            bank   <= '0;
            addr   <= '0;
        end else begin
            state  <= state_nx;
            load_q <= bus.conv_load_start;
            bank   <= bank_nx;
            addr   <= addr_nx;
        end
    end

    // Write ports are registered: one strobe cycle per accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ena_r     <= '0;
            in_addr_r    <= '0;
            in_data_r    <= '0;
            wt_ena_r     <= '0;
            wt_addr_r    <= '0;
            wt_data_r    <= '0;
            comp_start_r <= 1'b0;
            tile_done_r  <= 1'b0;
        end else begin
            in_ena_r <= '0;
            wt_ena_r <= '0;
            if (accept && state == LOAD_IN) begin
                in_ena_r  <= Tm'(1) << bank;
                in_addr_r <= addr;
                in_data_r <= bus.s_data;
            end
            if (accept && state == LOAD_WT) begin
                wt_ena_r  <= Tn'(1) << bank;
                wt_addr_r <= addr;
                wt_data_r <= bus.s_data;
            end
            comp_start_r <= (state == WAIT_DONE) && !bus.conv_computing_done;
            tile_done_r  <= (state == WAIT_DONE) && bus.conv_computing_done;
        end
    end

    assign bus.in_fm_wr_ena         = in_ena_r;
    assign bus.in_fm_wr_addr        = in_addr_r;
    assign bus.in_fm_wr_data        = in_data_r;
    assign bus.weight_wr_ena        = wt_ena_r;
    assign bus.weight_wr_addr       = wt_addr_r;
    assign bus.weight_wr_data       = wt_data_r;
    assign bus.conv_computing_start = comp_start_r;
    assign bus.tile_done            = tile_done_r;
endmodule

// File: tb/tb_conv_tile_loader.sv
// Directed bench for conv_tile_loader with Tm=2 Tr=4 Tc=4 Tn=2 K=3.
// 32 in_fm beats (16 per bank), 36 weight beats (18 per bank), data = beat.
module tb_conv_tile_loader;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TN = 2;
    localparam int TM = 2;
    localparam int TR = 4;
    localparam int TC = 4;
    localparam int KK = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv_tile_loader_if #(.AW(AW), .DW(DW), .Tn(TN), .Tm(TM)) bus();

    conv_tile_loader #(
        .AW(AW), .DW(DW), .Tn(TN), .Tm(TM), .Tr(TR), .Tc(TC), .K(KK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int beat     = 0;
    int cnt      = 0;
    int last_hs  = 0;
    bit mready     = 1'b0;
    bit mbusy      = 1'b0;
    bit exp_td     = 1'b0;
    bit pend_start = 1'b0;
    bit pend_done  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic rst_checks();
        chk("rst_in_ena",   64'(bus.in_fm_wr_ena), 64'(0));
        chk("rst_in_addr",  64'(bus.in_fm_wr_addr), 64'(0));
        chk("rst_in_data",  64'(bus.in_fm_wr_data), 64'(0));
        chk("rst_wt_ena",   64'(bus.weight_wr_ena), 64'(0));
        chk("rst_wt_addr",  64'(bus.weight_wr_addr), 64'(0));
        chk("rst_wt_data",  64'(bus.weight_wr_data), 64'(0));
        chk("rst_s_ready",  64'(bus.s_ready), 64'(0));
        chk("rst_start",    64'(bus.conv_computing_start), 64'(0));
        chk("rst_busy",     64'(bus.busy), 64'(0));
        chk("rst_tile_done", 64'(bus.tile_done), 64'(0));
    endtask

    // One clock: drive, check ready, step, then check write port and status.
    task automatic cyc(input bit v);
        bit hs;
        int b;
        int w;
        bus.s_valid = v;
        bus.s_data  = 32'(beat);
        chk("s_ready", 64'(bus.s_ready), 64'(mready));
        hs = v && mready;
        b  = beat;
        @(posedge clk);
        #1;
        cnt++;
        if (hs && b < 32) begin
            chk("in_ena",  64'(bus.in_fm_wr_ena), 64'(1 << (b / 16)));
            chk("in_addr", 64'(bus.in_fm_wr_addr), 64'(b % 16));
            chk("in_data", 64'(bus.in_fm_wr_data), 64'(b));
            chk("wt_ena_off", 64'(bus.weight_wr_ena), 64'(0));
        end else if (hs) begin
            w = b - 32;
            chk("wt_ena",  64'(bus.weight_wr_ena), 64'(1 << (w / 18)));
            chk("wt_addr", 64'(bus.weight_wr_addr), 64'(w % 18));
            chk("wt_data", 64'(bus.weight_wr_data), 64'(b));
            chk("in_ena_off", 64'(bus.in_fm_wr_ena), 64'(0));
        end else begin
            chk("in_ena_idle", 64'(bus.in_fm_wr_ena), 64'(0));
            chk("wt_ena_idle", 64'(bus.weight_wr_ena), 64'(0));
        end
        if (hs) begin
            beat++;
            if (beat == 68) begin
                mready  = 1'b0;
                last_hs = cnt;
            end
        end
        if (pend_start) begin
            pend_start = 1'b0;
            mready     = 1'b1;
            mbusy      = 1'b1;
            beat       = 0;
        end
        if (pend_done) begin
            pend_done = 1'b0;
            mbusy     = 1'b0;
            last_hs   = 0;
            exp_td    = 1'b1;
        end
        chk("busy", 64'(bus.busy), 64'(mbusy));
        chk("comp_start", 64'(bus.conv_computing_start),
            64'(last_hs != 0 && cnt >= last_hs + 2));
        chk("tile_done", 64'(bus.tile_done), 64'(exp_td));
        exp_td = 1'b0;
    endtask

    task automatic load_edge();
        if (bus.conv_load_start) begin
            bus.conv_load_start = 1'b0;
            cyc(1'b0);
        end
        bus.conv_load_start = 1'b1;
        pend_start = 1'b1;
        cnt = 0;
        cyc(1'b0);
    endtask

    task automatic do_load(input bit gaps, input bit poke, input int stop_at);
        int g;
        g = 0;
        while (beat < stop_at && g < 2000) begin
            bus.conv_computing_done = poke && (beat == 5);
            bus.conv_load_start     = !(poke && (beat == 40));
            cyc(gaps ? 1'($urandom_range(0, 1)) : 1'b1);
            g++;
        end
        bus.conv_computing_done = 1'b0;
        bus.conv_load_start     = 1'b1;
        chk("load_beats", 64'(beat), 64'(stop_at));
    endtask

    task automatic wait_done(input int n);
        int g;
        g = 0;
        while (cnt < last_hs + 2 && g < 10) begin
            cyc(1'b0);
            g++;
        end
        chk("start_up", 64'(bus.conv_computing_start), 64'(1));
        repeat (n - 1) cyc(1'b0);
        bus.conv_computing_done = 1'b1;
        pend_done = 1'b1;
        cyc(1'b0);
        bus.conv_computing_done = 1'b0;
        cyc(1'b0);
    endtask

    initial begin
        int g;
        bus.conv_load_start     = 1'b0;
        bus.s_valid             = 1'b0;
        bus.s_data              = '0;
        bus.conv_computing_done = 1'b0;
        #1;
        rst_checks();
        cyc(1'b0);
        cyc(1'b0);
        rst = 1'b0;
        cyc(1'b0);

        // full-rate load and start latency
        load_edge();
        do_load(1'b0, 1'b0, 68);
        g = 0;
        while (!bus.conv_computing_start && g < 20) begin
            cyc(1'b0);
            g++;
        end
        chk("load_latency", 64'(cnt), 64'(71));
        wait_done(10);

        // random valid gaps, restart at bank0 address 0
        load_edge();
        do_load(1'b1, 1'b0, 68);
        wait_done(10);

        // stray done during LOAD_IN, start toggle during LOAD_WT
        load_edge();
        do_load(1'b0, 1'b1, 68);
        wait_done(3);

        // reset mid-load after 20 in_fm beats
        load_edge();
        do_load(1'b1, 1'b0, 20);
        rst = 1'b1;
        #1;
        rst_checks();
        mready  = 1'b0;
        mbusy   = 1'b0;
        beat    = 0;
        last_hs = 0;
        bus.conv_load_start = 1'b0;
        bus.s_valid = 1'b0;
        cyc(1'b0);
        rst = 1'b0;
        cyc(1'b0);
        load_edge();
        do_load(1'b0, 1'b0, 68);
        wait_done(2);

        // level held high: no second load without a new edge
        repeat (6) cyc(1'b1);
        load_edge();
        do_load(1'b0, 1'b0, 68);
        wait_done(1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
